// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command front-end.
package alu_pkg;

    localparam int OPND_W  = 32;
    localparam int RES_W   = 64;
    localparam int SHIFT_W = 6;
    localparam int OPC_W   = 3;
    localparam int TAG_W   = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_MUL = 3'b010;
    localparam logic [OPC_W-1:0] OP_DIV = 3'b011;

    // One queued ALU command as it sits in the FIFO.
    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [SHIFT_W-1:0] shift;
        logic [OPND_W-1:0]  a;
        logic [OPND_W-1:0]  b;
    } alu_cmd_t;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_EXEC = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_e;

    // A divide with a zero divisor has no meaningful result; flag it.
    function automatic logic is_div_by_zero(input alu_cmd_t cmd);
        return (cmd.opcode == OP_DIV) && (cmd.b == {OPND_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is read combinationally.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  alu_cmd_t               wdata,
    input  logic                   pop,
    output alu_cmd_t               rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    alu_cmd_t           mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for main_alu: queues commands, issues them one at a time,
// waits ALU_LAT cycles, then presents the captured result on a valid/ready port.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPC_W-1:0]       cmd_opcode,
    input  logic [SHIFT_W-1:0]     cmd_shift,
    input  logic [OPND_W-1:0]      cmd_a,
    input  logic [OPND_W-1:0]      cmd_b,
    output logic [OPND_W-1:0]      alu_a,
    output logic [OPND_W-1:0]      alu_b,
    output logic [OPC_W-1:0]       alu_opcode,
    output logic [SHIFT_W-1:0]     alu_shift,
    input  logic [RES_W-1:0]       alu_out,
    input  logic                   alu_carry,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RES_W-1:0]       res_data,
    output logic                   res_carry,
    output logic                   res_err,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int LAT_W = $clog2(ALU_LAT + 1);

    localparam logic [1:0] ST_IDLE = SEQ_IDLE;
    localparam logic [1:0] ST_EXEC = SEQ_EXEC;
    localparam logic [1:0] ST_DONE = SEQ_DONE;

    logic [1:0]          state_q, state_d;
    logic [OPND_W-1:0]   alu_a_q, alu_a_d;
    logic [OPND_W-1:0]   alu_b_q, alu_b_d;
    logic [OPC_W-1:0]    alu_opcode_q, alu_opcode_d;
    logic [SHIFT_W-1:0]  alu_shift_q, alu_shift_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [TAG_W-1:0]    pend_tag_q, pend_tag_d;
    logic                pend_err_q, pend_err_d;
    logic                res_valid_q, res_valid_d;
    logic [RES_W-1:0]    res_data_q, res_data_d;
    logic                res_carry_q, res_carry_d;
    logic                res_err_q, res_err_d;
    logic [TAG_W-1:0]    res_tag_q, res_tag_d;

    alu_cmd_t            push_cmd_s;
    alu_cmd_t            head_s;
    logic                push_s;
    logic                issue_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CNT_W-1:0]    fifo_count_s;

    assign push_cmd_s = '{opcode: cmd_opcode, shift: cmd_shift, a: cmd_a, b: cmd_b};
    // Ready depends only on stored occupancy, so a full FIFO never accepts even on a pop cycle.
    assign cmd_ready  = !fifo_full_s;
    assign push_s     = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (push_cmd_s),
        .pop   (issue_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer FSM: issue from the FIFO head, count settle latency, capture and hand off the result.
    always_comb begin
        state_d      = state_q;
        issue_s      = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_shift_d  = alu_shift_q;
        lat_cnt_d    = lat_cnt_q;
        tag_d        = tag_q;
        pend_tag_d   = pend_tag_q;
        pend_err_d   = pend_err_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_carry_d  = res_carry_q;
        res_err_d    = res_err_q;
        res_tag_d    = res_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_EXEC: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    res_data_d  = alu_out;
                    res_carry_d = alu_carry;
                    res_err_d   = pend_err_q;
                    res_tag_d   = pend_tag_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty_s) begin
                        issue_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase

        // Issuing pops the head and loads the ALU-facing registers; they stay put until the next issue.
        if (issue_s) begin
            alu_a_d      = head_s.a;
            alu_b_d      = head_s.b;
            alu_opcode_d = head_s.opcode;
            alu_shift_d  = head_s.shift;
            pend_err_d   = is_div_by_zero(head_s);
            pend_tag_d   = tag_q;
            tag_d        = tag_q + TAG_W'(1);
            lat_cnt_d    = LAT_W'(ALU_LAT);
            state_d      = ST_EXEC;
        end else begin
            tag_d = tag_q;
        end
    end

    // State, ALU-drive and result registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= {OPND_W{1'b0}};
            alu_b_q      <= {OPND_W{1'b0}};
            alu_opcode_q <= {OPC_W{1'b0}};
            alu_shift_q  <= {SHIFT_W{1'b0}};
            lat_cnt_q    <= {LAT_W{1'b0}};
            tag_q        <= {TAG_W{1'b0}};
            pend_tag_q   <= {TAG_W{1'b0}};
            pend_err_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= {RES_W{1'b0}};
            res_carry_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_tag_q    <= {TAG_W{1'b0}};
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_shift_q  <= alu_shift_d;
            lat_cnt_q    <= lat_cnt_d;
            tag_q        <= tag_d;
            pend_tag_q   <= pend_tag_d;
            pend_err_q   <= pend_err_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_carry_q  <= res_carry_d;
            res_err_q    <= res_err_d;
            res_tag_q    <= res_tag_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_shift  = alu_shift_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_carry  = res_carry_q;
    assign res_err    = res_err_q;
    assign res_tag    = res_tag_q;
    assign fifo_count = fifo_count_s;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural main_alu stand-in.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = 3'd0;
    logic [5:0]  cmd_shift = 6'd0;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [5:0]  alu_shift;
    logic [63:0] alu_out_s;
    logic        alu_carry_s;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_data;
    logic        res_carry, res_err;
    logic [3:0]  res_tag;
    logic        busy;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] exp_d [8];
    logic [3:0]  exp_t [8];

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] data;
        logic        carry;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    alu_op_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_shift(cmd_shift), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_shift(alu_shift),
        .alu_out(alu_out_s), .alu_carry(alu_carry_s),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_err(res_err), .res_tag(res_tag),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Stand-in for main_alu: combinational from the registered alu_* drive.
    always_comb begin
        alu_out_s   = 64'd0;
        alu_carry_s = 1'b0;
        case (alu_opcode)
            3'b000: begin
                alu_out_s   = 64'(alu_a) + 64'(alu_b);
                alu_carry_s = alu_out_s[32];
            end
            3'b001: begin
                alu_out_s   = 64'(alu_a) - 64'(alu_b);
                alu_carry_s = (alu_a < alu_b);
            end
            3'b010: alu_out_s = 64'(alu_a) * 64'(alu_b);
            3'b011: alu_out_s = (alu_b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(alu_a / alu_b);
            default: begin
                alu_out_s   = {alu_a, alu_b} ^ {58'd0, alu_shift};
                alu_carry_s = ^alu_shift;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({p, ".res_valid"}, 64'(res_valid), 64'd0);
        chk({p, ".res_carry"}, 64'(res_carry), 64'd0);
        chk({p, ".res_err"}, 64'(res_err), 64'd0);
        chk({p, ".busy"}, 64'(busy), 64'd0);
        chk({p, ".res_data"}, res_data, 64'd0);
        chk({p, ".res_tag"}, 64'(res_tag), 64'd0);
        chk({p, ".alu_ab"}, {alu_a, alu_b}, 64'd0);
        chk({p, ".alu_op_sh"}, 64'({alu_opcode, alu_shift}), 64'd0);
        chk({p, ".fifo_count"}, 64'(fifo_count), 64'd0);
    endtask

    // Offer one command and return right after the edge that accepts it.
    task automatic push(input logic [2:0] op, input logic [5:0] sh, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        cmd_opcode = op; cmd_shift = sh; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL push_timeout: cmd_ready actual=0 required=1");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Push one command into an idle sequencer, check latency, ALU drive and result, then consume it.
    task automatic run_one(input string nm, input logic [2:0] op, input logic [5:0] sh,
                           input logic [31:0] a, input logic [31:0] b, input logic [63:0] d,
                           input logic c, input logic e, input logic [3:0] tg);
        int n;
        push(op, sh, a, b);
        n = 1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
            if (n == 2) begin
                chk({nm, ".exec_alu_ab"}, {alu_a, alu_b}, {a, b});
                chk({nm, ".exec_alu_op"}, 64'({alu_opcode, alu_shift}), 64'({op, sh}));
            end
        end
        chk({nm, ".latency"}, 64'(n), 64'd3);
        chk({nm, ".done_alu_ab"}, {alu_a, alu_b}, {a, b});
        chk({nm, ".res_data"}, res_data, d);
        chk({nm, ".res_carry"}, 64'(res_carry), 64'(c));
        chk({nm, ".res_err"}, 64'(res_err), 64'(e));
        chk({nm, ".res_tag"}, 64'(res_tag), 64'(tg));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, ".valid_drop"}, 64'(res_valid), 64'd0);
    endtask

    // Consume n results with res_ready held high, comparing against exp_d/exp_t.
    task automatic drain(input string nm, input int n, input bit gap_chk);
        int last;
        int guard;
        last = 0;
        res_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!res_valid && guard < 20) begin
                tick();
                guard++;
            end
            chk($sformatf("%s.valid%0d", nm, k), 64'(res_valid), 64'd1);
            chk($sformatf("%s.data%0d", nm, k), res_data, exp_d[k]);
            chk($sformatf("%s.tag%0d", nm, k), 64'(res_tag), 64'(exp_t[k]));
            if (gap_chk && k > 0) chk($sformatf("%s.gap%0d", nm, k), 64'(cyc - last), 64'd2);
            last = cyc;
            tick();
        end
        res_ready = 1'b0;
    endtask

    initial begin
        int seen;

        vecs[0] = '{3'b000, 6'd0, 32'd23, 32'd12, 64'd35, 1'b0, 1'b0};
        vecs[1] = '{3'b000, 6'd0, 32'hFFFF_FFFF, 32'd1, 64'h1_0000_0000, 1'b1, 1'b0};
        vecs[2] = '{3'b001, 6'd0, 32'd5, 32'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
        vecs[3] = '{3'b010, 6'd0, 32'h1_0000, 32'h1_0000, 64'h1_0000_0000, 1'b0, 1'b0};
        vecs[4] = '{3'b011, 6'd0, 32'd103, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{3'b011, 6'd0, 32'd103, 32'd10, 64'd10, 1'b0, 1'b0};
        vecs[6] = '{3'b100, 6'h03, 32'h1234_5678, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF3, 1'b0, 1'b0};
        vecs[7] = '{3'b111, 6'h01, 32'd0, 32'd0, 64'd1, 1'b1, 1'b0};
        vecs[8] = '{3'b001, 6'd0, 32'd9, 32'd0, 64'd9, 1'b0, 1'b0};

        // Reset, reset values, then the directed single-command table.
        do_reset(3);
        chk_reset_vals("reset");
        for (int i = 0; i < 9; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].sh, vecs[i].a, vecs[i].b,
                    vecs[i].data, vecs[i].carry, vecs[i].err, 4'(i));
        end

        // Backpressure: one issued, four queued, then in-order drain every two cycles.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            push(3'b000, 6'd0, 32'(i * 100), 32'(i));
            exp_d[i] = 64'(i * 101);
            exp_t[i] = 4'(i);
        end
        chk("full.fifo_count", 64'(fifo_count), 64'd4);
        chk("full.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("full.busy", 64'(busy), 64'd1);
        drain("full", 5, 1'b1);
        chk("full.empty_after", 64'(busy), 64'd0);

        // Simultaneous push and pop at occupancy 2.
        do_reset(2);
        push(3'b000, 6'd0, 32'd1, 32'd1);
        push(3'b000, 6'd0, 32'd2, 32'd2);
        push(3'b000, 6'd0, 32'd3, 32'd3);
        chk("pp.count_before", 64'(fifo_count), 64'd2);
        chk("pp.valid_a", 64'(res_valid), 64'd1);
        chk("pp.data_a", res_data, 64'd2);
        chk("pp.tag_a", 64'(res_tag), 64'd0);
        chk("pp.cmd_ready", 64'(cmd_ready), 64'd1);
        cmd_opcode = 3'b000; cmd_shift = 6'd0; cmd_a = 32'd4; cmd_b = 32'd4;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("pp.count_after", 64'(fifo_count), 64'd2);
        exp_d[0] = 64'd4; exp_t[0] = 4'd1;
        exp_d[1] = 64'd6; exp_t[1] = 4'd2;
        exp_d[2] = 64'd8; exp_t[2] = 4'd3;
        drain("pp", 3, 1'b0);

        // Reset while a command is executing with three more queued.
        do_reset(2);
        for (int i = 0; i < 5; i++) push(3'b000, 6'd0, 32'(i + 50), 32'd7);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("mid.count_exec", 64'(fifo_count), 64'd3);
        chk("mid.valid_exec", 64'(res_valid), 64'd0);
        do_reset(2);
        chk_reset_vals("mid");
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (res_valid) seen++;
        end
        chk("mid.flushed_valid", 64'(seen), 64'd0);
        run_one("mid.next", 3'b000, 6'd0, 32'd40, 32'd2, 64'd42, 1'b0, 1'b0, 4'd0);

        // Tag wrap over 17 issues.
        do_reset(2);
        for (int i = 0; i < 17; i++) begin
            run_one($sformatf("wrap%0d", i), 3'b000, 6'(i), 32'(3 * i + 1), 32'(i),
                    64'(4 * i + 1), 1'b0, 1'b0, 4'(i % 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: sim_time actual=200000 required=<200000");
        $fatal(1);
    end

endmodule
